// File: rtl/matrix_add_sub_unit.sv
// matrix_add_sub_unit: element-wise 4x4 add/subtract responder.
// Two operand matrices are written over a wide bus, then one result row is
// produced per clock. The result is presented with flag=1 until the engine
// acknowledges it with a read.
//
// Bus handshake: the engine is the only initiator. A transaction is en=1 at
// a rising clock edge; rw=1 writes an operand (matSel picks A/B), rw=0 reads
// (acknowledges) the result. Writes are accepted only in IDLE/LOAD, reads
// only in DONE. Anything else is silently ignored. There is no back-pressure
// signal other than busy (CALC) and flag (DONE).
module matrix_add_sub_unit #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4
) (
    input  logic                      clk,
    input  logic                      RESET,
    output logic [DIM*DIM*ELEM_W-1:0] dataOut,
    output logic                      flag,
    output logic                      busy,
    input  logic [DIM*DIM*ELEM_W-1:0] dataIn,
    input  logic                      en,
    input  logic                      rw,
    input  logic                      matSel,
    input  logic                      add1sub0,
    output logic [1:0]                o_dbg_state
);

    localparam int ROW_BITS = DIM * ELEM_W;
    localparam int BUS_W    = DIM * ROW_BITS;
    localparam int ROW_W    = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [BUS_W-1:0]    r_a;
    logic [BUS_W-1:0]    r_b;
    logic [BUS_W-1:0]    r_dout;
    logic                r_flag;
    logic                r_busy;
    logic                r_a_valid;
    logic                r_b_valid;
    logic [ROW_W-1:0]    r_row;
    logic                r_op;

    logic [ROW_BITS-1:0] w_a_row;
    logic [ROW_BITS-1:0] w_b_row;
    logic [ROW_BITS-1:0] w_row_res;
    logic                w_wr;
    logic                w_rd;
    logic                w_a_valid_nxt;
    logic                w_b_valid_nxt;

    assign w_wr          = en & rw;
    assign w_rd          = en & ~rw;
    assign w_a_valid_nxt = r_a_valid | ~matSel;
    assign w_b_valid_nxt = r_b_valid | matSel;

    assign w_a_row = r_a[int'(r_row) * ROW_BITS +: ROW_BITS];
    assign w_b_row = r_b[int'(r_row) * ROW_BITS +: ROW_BITS];

    // Result of the current row: wrap-around add or subtract per column.
    always_comb begin
        w_row_res = '0;
        for (int c = 0; c < DIM; c++) begin
            if (r_op) begin
                w_row_res[c*ELEM_W +: ELEM_W] = w_a_row[c*ELEM_W +: ELEM_W] + w_b_row[c*ELEM_W +: ELEM_W];
            end else begin
                w_row_res[c*ELEM_W +: ELEM_W] = w_a_row[c*ELEM_W +: ELEM_W] - w_b_row[c*ELEM_W +: ELEM_W];
            end
        end
    end

    // Control FSM with operand capture, row-serial datapath and registered outputs.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_dout    <= '0;
            r_flag    <= 1'b0;
            r_busy    <= 1'b0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_row     <= '0;
            r_op      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_wr) begin
                        if (matSel) begin
                            r_b <= dataIn;
                        end else begin
                            r_a <= dataIn;
                        end
                        r_a_valid <= w_a_valid_nxt;
                        r_b_valid <= w_b_valid_nxt;
                        if (w_a_valid_nxt && w_b_valid_nxt) begin
                            // Operation is frozen here; later add1sub0 changes are ignored.
                            r_op    <= add1sub0;
                            r_row   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_CALC: begin
                    r_dout[int'(r_row) * ROW_BITS +: ROW_BITS] <= w_row_res;
                    r_row <= r_row + 1'b1;
                    if (r_row == ROW_W'(DIM - 1)) begin
                        r_busy  <= 1'b0;
                        r_flag  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result stays on dataOut after the acknowledge until the next CALC.
                    if (w_rd) begin
                        r_flag    <= 1'b0;
                        r_a_valid <= 1'b0;
                        r_b_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dataOut     = r_dout;
    assign flag        = r_flag;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matrix_add_sub_unit.sv
// Bench for matrix_add_sub_unit: directed cases plus randomized operand
// pairs checked against a plain-arithmetic matrix model.
module tb_matrix_add_sub_unit;

    localparam int BW = 256;

    logic          clk;
    logic          RESET;
    logic [BW-1:0] dataOut;
    logic          flag;
    logic          busy;
    logic [BW-1:0] dataIn;
    logic          en;
    logic          rw;
    logic          matSel;
    logic          add1sub0;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] last_res;

    matrix_add_sub_unit #(.ELEM_W(16), .DIM(4)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .dataOut    (dataOut),
        .flag       (flag),
        .busy       (busy),
        .dataIn     (dataIn),
        .en         (en),
        .rw         (rw),
        .matSel     (matSel),
        .add1sub0   (add1sub0),
        .o_dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: element-wise arithmetic on 16-bit values, mod 2^16
    function automatic logic [BW-1:0] ref_result(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit add);
        logic [BW-1:0] res;
        int x, y, s;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                x = int'(a[16*(4*r+c) +: 16]);
                y = int'(b[16*(4*r+c) +: 16]);
                s = add ? (x + y) : (x - y);
                s = s & 32'h0000FFFF;
                res[16*(4*r+c) +: 16] = s[15:0];
            end
        end
        return res;
    endfunction

    function automatic logic [BW-1:0] fill(input logic [15:0] v);
        logic [BW-1:0] m;
        for (int i = 0; i < 16; i++) m[16*i +: 16] = v;
        return m;
    endfunction

    function automatic logic [BW-1:0] rand_mat();
        logic [BW-1:0] m;
        for (int i = 0; i < 8; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    // driver tasks: all start and end 1 time unit after a rising edge
    task automatic step(input bit junk);
        if (junk) begin
            en       = 1'($urandom_range(0, 1));
            rw       = 1'($urandom_range(0, 1));
            matSel   = 1'($urandom_range(0, 1));
            add1sub0 = 1'($urandom_range(0, 1));
            dataIn   = {BW{1'b1}};
        end else begin
            en = 1'b0;
        end
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic bus_write(input bit sel, input logic [BW-1:0] d, input bit op);
        dataIn   = d;
        matSel   = sel;
        add1sub0 = op;
        rw       = 1'b1;
        en       = 1'b1;
        @(posedge clk);
        #1;
        en     = 1'b0;
        dataIn = rand_mat();
    endtask

    task automatic bus_read();
        rw = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Wait for flag after the completing write, checking busy and latency,
    // then exercise the DONE state and acknowledge.
    task automatic finish(input string tag, input bit junk);
        int cycles;
        logic [BW-1:0] exp;
        cycles = 0;
        while (!flag && cycles < 20) begin
            check_val({tag, "_busy_calc"}, BW'(busy), BW'(1));
            step(junk);
            cycles++;
        end
        check_val({tag, "_latency"}, BW'(cycles), BW'(4));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_val({tag, "_flag"}, BW'(flag), BW'(1));
        check_val({tag, "_busy_done"}, BW'(busy), BW'(0));
        check_val({tag, "_result"}, dataOut, exp);
        // write in DONE must be ignored
        bus_write(1'($urandom_range(0, 1)), {BW{1'b1}}, 1'($urandom_range(0, 1)));
        check_val({tag, "_done_wr_flag"}, BW'(flag), BW'(1));
        check_val({tag, "_done_wr_data"}, dataOut, exp);
        bus_read();
        check_val({tag, "_ack_flag"}, BW'(flag), BW'(0));
        check_val({tag, "_ack_data"}, dataOut, exp);
        last_res = exp;
    endtask

    task automatic run_pair(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit op,
                            input bit junk, input string tag);
        bus_write(1'b0, a, ~op);
        check_val({tag, "_load_busy"}, BW'(busy), BW'(0));
        exp_q.push_back(ref_result(a, b, op));
        bus_write(1'b1, b, op);
        finish(tag, junk);
    endtask

    // main sequence
    initial begin
        logic [BW-1:0] a, b, first_junk, inc;
        bit op, b_first;

        RESET = 1'b0; en = 1'b0; rw = 1'b0; matSel = 1'b0; add1sub0 = 1'b0; dataIn = '0;
        last_res = '0;
        #23;
        check_val("rst_flag", BW'(flag), BW'(0));
        check_val("rst_busy", BW'(busy), BW'(0));
        check_val("rst_data", dataOut, '0);
        check_val("rst_state", BW'(dbg_state), BW'(0));
        RESET = 1'b1;
        @(posedge clk);
        #1;

        // add: A(r,c)=4r+c, B=1
        for (int i = 0; i < 16; i++) inc[16*i +: 16] = 16'(i);
        run_pair(inc, fill(16'h0001), 1'b1, 1'b0, "add");
        // subtract and add wrap-around
        run_pair(fill(16'h0000), fill(16'h0003), 1'b0, 1'b1, "sub_wrap");
        check_val("sub_wrap_val", last_res, fill(16'hFFFD));
        run_pair(fill(16'h7FFF), fill(16'h0001), 1'b1, 1'b1, "add_nosat");
        check_val("add_nosat_val", last_res, fill(16'h8000));

        // read in IDLE and LOAD is ignored
        bus_read();
        check_val("idle_rd_flag", BW'(flag), BW'(0));
        check_val("idle_rd_data", dataOut, last_res);
        // A, A overwrite, then B
        bus_write(1'b0, fill(16'h0002), 1'b0);
        bus_read();
        check_val("load_rd_flag", BW'(flag), BW'(0));
        check_val("load_rd_busy", BW'(busy), BW'(0));
        bus_write(1'b0, fill(16'h0010), 1'b0);
        check_val("ovr_busy", BW'(busy), BW'(0));
        exp_q.push_back(fill(16'h0015));
        bus_write(1'b1, fill(16'h0005), 1'b1);
        finish("overwrite", 1'b1);

        // reset mid-CALC
        bus_write(1'b0, rand_mat(), 1'b1);
        bus_write(1'b1, rand_mat(), 1'b1);
        step(1'b0);
        step(1'b0);
        #2;
        RESET = 1'b0;
        #1;
        check_val("midrst_flag", BW'(flag), BW'(0));
        check_val("midrst_busy", BW'(busy), BW'(0));
        check_val("midrst_data", dataOut, '0);
        #1;
        RESET = 1'b1;
        @(posedge clk);
        #1;
        b = rand_mat();
        bus_write(1'b1, b, 1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check_val("postrst_busy", BW'(busy), BW'(0));
        check_val("postrst_flag", BW'(flag), BW'(0));
        a = rand_mat();
        exp_q.push_back(ref_result(a, b, 1'b0));
        bus_write(1'b0, a, 1'b0);
        finish("postrst", 1'b0);

        // randomized pairs with random order, overwrites and ignored reads
        for (int n = 0; n < 16; n++) begin
            a = rand_mat();
            b = rand_mat();
            op = 1'($urandom_range(0, 1));
            b_first = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                first_junk = rand_mat();
                bus_write(b_first, first_junk, 1'($urandom_range(0, 1)));
            end
            bus_write(b_first, b_first ? b : a, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                bus_read();
                check_val("rnd_load_rd_flag", BW'(flag), BW'(0));
            end
            check_val("rnd_load_busy", BW'(busy), BW'(0));
            exp_q.push_back(ref_result(a, b, op));
            bus_write(~b_first, b_first ? a : b, op);
            finish("rnd", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
